// File: rtl/data_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter
//                (FSM state encoding, requester port indices).
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arb_pkg;

    // Arbiter FSM: one idle/arbitration cycle, one memory access cycle
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Requester indices as seen by the round-robin pick
    localparam logic PORT_CORE = 1'b0;   // core load/store unit
    localparam logic PORT_DMA  = 1'b1;   // DMA / debug loader

endpackage : data_mem_arb_pkg
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin pick. A lone request wins
//                outright; on a tie the port that was not granted last wins.
//                An active lock forces the pick to the lock owner and masks
//                the other requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_lock_valid,
    input  logic       i_lock_owner,
    output logic       o_any,
    output logic       o_sel
);

    // Winner selection: lock owner first, otherwise round-robin on ties
    always_comb begin
        o_any = 1'b0;
        o_sel = PORT_CORE;
        if (i_lock_valid) begin
            o_any = i_req[i_lock_owner];
            o_sel = i_lock_owner;
        end else begin
            o_any = |i_req;
            case (i_req)
                2'b01:   o_sel = PORT_CORE;
                2'b10:   o_sel = PORT_DMA;
                2'b11:   o_sel = ~i_last;
                default: o_sel = PORT_CORE;
            endcase
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Shares a single-port word-addressed data memory between the
//                core load/store unit (port 0) and the DMA/debug loader
//                (port 1). Registered req/gnt handshake, round-robin
//                arbitration, registered read data. Sole driver of the memory
//                control pins; at most one access every two cycles.
//  Options     : define ARB_LOCK_EN to add p0/p1 lock inputs that keep the
//                arbiter on one requester for atomic read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    // port 0: core load/store unit
    input  logic              i_p0_req,
    input  logic              i_p0_we,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    output logic              o_p0_gnt,
    output logic              o_p0_rvalid,
    output logic [DATA_W-1:0] o_p0_rdata,
    // port 1: DMA / debug loader
    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wdata,
    output logic              o_p1_gnt,
    output logic              o_p1_rvalid,
    output logic [DATA_W-1:0] o_p1_rdata,
`ifdef ARB_LOCK_EN
    input  logic              i_p0_lock,
    input  logic              i_p1_lock,
`endif
    // memory side
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    // The memory decodes addr[MEM_AW-1:2]; it must hold at least one word bit
    // and fit inside the byte address.
    if ((MEM_AW < 3) || (MEM_AW > ADDR_W)) begin : g_bad_mem_aw
        $error("data_mem_arbiter: MEM_AW must be in [3, ADDR_W]");
    end

    state_t             r_state;
    logic               r_sel;
    logic               r_last_gnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_p0_gnt;
    logic               r_p1_gnt;
    logic               r_p0_rvalid;
    logic               r_p1_rvalid;
    logic [DATA_W-1:0]  r_p0_rdata;
    logic [DATA_W-1:0]  r_p1_rdata;

    logic               w_any;
    logic               w_sel;
    logic               w_lock_active;
    logic               w_lock_owner;
    logic               w_win_we;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]  w_win_wdata;

`ifdef ARB_LOCK_EN
    logic r_lock_valid;
    logic r_lock_owner;
    logic w_owner_lock;
    logic w_sel_lock;

    // The lock only stays in force while its owner keeps asserting lock
    assign w_owner_lock  = r_lock_owner ? i_p1_lock : i_p0_lock;
    assign w_sel_lock    = r_sel ? i_p1_lock : i_p0_lock;
    assign w_lock_active = r_lock_valid & w_owner_lock;
    assign w_lock_owner  = r_lock_owner;

    // Lock register: taken during the owner's access, dropped in IDLE once
    // the owner deasserts lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= PORT_CORE;
        end else if (r_state == ST_ACCESS) begin
            if (w_sel_lock) begin
                r_lock_valid <= 1'b1;
                r_lock_owner <= r_sel;
            end
        end else if (r_lock_valid && !w_owner_lock) begin
            r_lock_valid <= 1'b0;
        end
    end
`else
    assign w_lock_active = 1'b0;
    assign w_lock_owner  = PORT_CORE;
`endif

    rr_arb2 u_rr_arb2 (
        .i_req        ({i_p1_req, i_p0_req}),
        .i_last       (r_last_gnt),
        .i_lock_valid (w_lock_active),
        .i_lock_owner (w_lock_owner),
        .o_any        (w_any),
        .o_sel        (w_sel)
    );

    // Request fields of the winning port
    assign w_win_we    = w_sel ? i_p1_we    : i_p0_we;
    assign w_win_addr  = w_sel ? i_p1_addr  : i_p0_addr;
    assign w_win_wdata = w_sel ? i_p1_wdata : i_p0_wdata;

    // Arbitration FSM: latch the winner in IDLE, drive memory for one cycle
    // in ACCESS and capture read data at the closing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= PORT_CORE;
            r_last_gnt  <= PORT_DMA;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_p0_gnt    <= 1'b0;
            r_p1_gnt    <= 1'b0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_p0_rvalid <= 1'b0;
                    r_p1_rvalid <= 1'b0;
                    if (w_any) begin
                        r_state     <= ST_ACCESS;
                        r_sel       <= w_sel;
                        r_last_gnt  <= w_sel;
                        r_mem_addr  <= w_win_addr;
                        r_mem_wdata <= w_win_wdata;
                        r_mem_write <= w_win_we;
                        r_mem_read  <= ~w_win_we;
                        r_p0_gnt    <= (w_sel == PORT_CORE);
                        r_p1_gnt    <= (w_sel == PORT_DMA);
                    end
                end
                ST_ACCESS: begin
                    r_state     <= ST_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_p0_gnt    <= 1'b0;
                    r_p1_gnt    <= 1'b0;
                    if (r_mem_read) begin
                        if (r_sel == PORT_DMA) begin
                            r_p1_rdata  <= i_mem_rdata;
                            r_p1_rvalid <= 1'b1;
                        end else begin
                            r_p0_rdata  <= i_mem_rdata;
                            r_p0_rvalid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_p0_gnt    = r_p0_gnt;
    assign o_p1_gnt    = r_p1_gnt;
    assign o_p0_rvalid = r_p0_rvalid;
    assign o_p1_rvalid = r_p1_rvalid;
    assign o_p0_rdata  = r_p0_rdata;
    assign o_p1_rdata  = r_p1_rdata;

endmodule : data_mem_arbiter
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Self-checking bench for data_mem_arbiter with a behavioural
//                1K-word memory attached to the memory pins. Directed
//                per-cycle vectors plus hand-written reset and lock sequences.
//                Build with ARB_LOCK_EN to exercise the lock inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_lock = 1'b0, p1_lock = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    int n_checks = 0;
    int n_errors = 0;

    // one record per clock cycle: inputs applied, outputs expected after the edge
    typedef struct packed {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mw, mr, v0, v1;
        logic [31:0] rd0, rd1;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl [0:21];

    // behavioural memory: 1K words, addr[11:2] decoded, combinational read
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_AW(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_p0_req    (p0_req),
        .i_p0_we     (p0_we),
        .i_p0_addr   (p0_addr),
        .i_p0_wdata  (p0_wdata),
        .o_p0_gnt    (p0_gnt),
        .o_p0_rvalid (p0_rvalid),
        .o_p0_rdata  (p0_rdata),
        .i_p1_req    (p1_req),
        .i_p1_we     (p1_we),
        .i_p1_addr   (p1_addr),
        .i_p1_wdata  (p1_wdata),
        .o_p1_gnt    (p1_gnt),
        .o_p1_rvalid (p1_rvalid),
        .o_p1_rdata  (p1_rdata),
`ifdef ARB_LOCK_EN
        .i_p0_lock   (p0_lock),
        .i_p1_lock   (p1_lock),
`endif
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .i_mem_rdata (mem_rdata)
    );

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic g0, input logic g1, input logic mw, input logic mr,
        input logic v0, input logic v1, input logic [31:0] rd0, input logic [31:0] rd1,
        input logic [31:0] ea);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mw = mw; v.mr = mr; v.v0 = v0; v.v1 = v1;
        v.rd0 = rd0; v.rd1 = rd1; v.ea = ea;
        return v;
    endfunction

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // apply one vector at the falling edge, compare #1 after the rising edge
    task automatic cyc(input string nm, input vec_t v);
        @(negedge clk);
        p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
        p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
        @(posedge clk);
        #1;
        check({nm, " gnt/mem/rvalid/rdata"},
              {10'd0, p0_gnt, p1_gnt, mem_write, mem_read, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata},
              {10'd0, v.g0, v.g1, v.mw, v.mr, v.v0, v.v1, v.rd0, v.rd1});
        if (v.mw || v.mr)
            check({nm, " mem_addr"}, {48'd0, mem_addr}, {48'd0, v.ea});
        if (v.mw)
            check({nm, " mem_wdata"}, {48'd0, mem_wdata}, {48'd0, (v.g0 ? v.d0 : v.d1)});
    endtask

    localparam logic [31:0] W1 = 32'hC0DE_0001;  // initial word 1 (addr 0x04)
    localparam logic [31:0] W4 = 32'hC0DE_0004;  // initial word 4 (addr 0x10)
    localparam logic [31:0] W8 = 32'hC0DE_0008;  // initial word 8 (addr 0x20)
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] AA = 32'hA5A5_0001;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;

        // both reads held from reset: p0, p1, p0, p1 with a grant every other cycle
        tbl[0]  = mk(H,L,32'h10,0, H,L,32'h4,0, H,L,L,H,L,L, 0,  0,  32'h10);
        tbl[1]  = mk(H,L,32'h10,0, H,L,32'h4,0, L,L,L,L,H,L, W4, 0,  0);
        tbl[2]  = mk(H,L,32'h10,0, H,L,32'h4,0, L,H,L,H,L,L, W4, 0,  32'h4);
        tbl[3]  = mk(H,L,32'h10,0, H,L,32'h4,0, L,L,L,L,L,H, W4, W1, 0);
        tbl[4]  = mk(H,L,32'h10,0, H,L,32'h4,0, H,L,L,H,L,L, W4, W1, 32'h10);
        tbl[5]  = mk(H,L,32'h10,0, H,L,32'h4,0, L,L,L,L,H,L, W4, W1, 0);
        tbl[6]  = mk(H,L,32'h10,0, H,L,32'h4,0, L,H,L,H,L,L, W4, W1, 32'h4);
        tbl[7]  = mk(H,L,32'h10,0, H,L,32'h4,0, L,L,L,L,L,H, W4, W1, 0);
        // p0 write 0xDEADBEEF @0x10, then read it back (rvalid two cycles after req)
        tbl[8]  = mk(H,H,32'h10,DB, L,L,0,0, H,L,H,L,L,L, W4, W1, 32'h10);
        tbl[9]  = mk(H,H,32'h10,DB, L,L,0,0, L,L,L,L,L,L, W4, W1, 0);
        tbl[10] = mk(H,L,32'h10,0,  L,L,0,0, H,L,L,H,L,L, W4, W1, 32'h10);
        tbl[11] = mk(H,L,32'h10,0,  L,L,0,0, L,L,L,L,H,L, DB, W1, 0);
        // p0 write 0x55 @0x4; p1 read raised during that access waits for IDLE
        tbl[12] = mk(H,H,32'h4,32'h55, L,L,0,0,     H,L,H,L,L,L, DB, W1, 32'h4);
        tbl[13] = mk(H,H,32'h4,32'h55, H,L,32'h4,0, L,L,L,L,L,L, DB, W1, 0);
        tbl[14] = mk(L,L,0,0,          H,L,32'h4,0, L,H,L,H,L,L, DB, W1, 32'h4);
        tbl[15] = mk(L,L,0,0,          H,L,32'h4,0, L,L,L,L,L,H, DB, 32'h55, 0);
        // aliasing above the decoded range and ignored misalignment
        tbl[16] = mk(H,H,32'h1010,AA, L,L,0,0,      H,L,H,L,L,L, DB, 32'h55, 32'h1010);
        tbl[17] = mk(H,H,32'h1010,AA, L,L,0,0,      L,L,L,L,L,L, DB, 32'h55, 0);
        tbl[18] = mk(L,L,0,0,         H,L,32'h10,0, L,H,L,H,L,L, DB, 32'h55, 32'h10);
        tbl[19] = mk(L,L,0,0,         H,L,32'h10,0, L,L,L,L,L,H, DB, AA, 0);
        tbl[20] = mk(H,L,32'h13,0,    L,L,0,0,      H,L,L,H,L,L, DB, AA, 32'h13);
        tbl[21] = mk(H,L,32'h13,0,    L,L,0,0,      L,L,L,L,H,L, AA, AA, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs",
              {10'd0, p0_gnt, p1_gnt, mem_write, mem_read, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata},
              80'd0);
        check("reset mem_addr/wdata", {16'd0, mem_addr, mem_wdata}, 80'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) cyc($sformatf("vec%0d", i), tbl[i]);

        // asynchronous reset in the middle of a write access
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h1234;
        p1_req = 1'b0;
        @(posedge clk);
        #1;
        check("rst-mid gnt+write", {78'd0, p0_gnt, mem_write}, {78'd0, 2'b11});
        #2;
        rst = 1'b1;
        #1;
        check("rst-mid outputs cleared",
              {10'd0, p0_gnt, p1_gnt, mem_write, mem_read, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata},
              80'd0);
        @(negedge clk);
        p0_req = 1'b0; p0_we = 1'b0;
        @(posedge clk);
        #1;
        check("rst-mid mem 0x20 kept", {48'd0, mem[8]}, {48'd0, W8});
        @(negedge clk);
        rst = 1'b0;
        // after reset, a tie goes to port 0 again
        cyc("post-rst tie p0", mk(H,L,32'h20,0, H,L,32'h4,0, H,L,L,H,L,L, 0,  0,      32'h20));
        cyc("post-rst p0 data", mk(H,L,32'h20,0, H,L,32'h4,0, L,L,L,L,H,L, W8, 0,      0));
        cyc("post-rst p1 gnt",  mk(L,L,0,0,      H,L,32'h4,0, L,H,L,H,L,L, W8, 0,      32'h4));
        cyc("post-rst p1 data", mk(L,L,0,0,      H,L,32'h4,0, L,L,L,L,L,H, W8, 32'h55, 0));

        // p1 read/write pair with lock while p0 keeps requesting
        p1_lock = 1'b1;
        cyc("lk p1 read",  mk(L,L,0,0,      H,L,32'h4,0, L,H,L,H,L,L, W8, 32'h55, 32'h4));
        cyc("lk p0 raise", mk(H,L,32'h10,0, H,L,32'h4,0, L,L,L,L,L,H, W8, 32'h55, 0));
`ifdef ARB_LOCK_EN
        cyc("lk p1 write", mk(H,L,32'h10,0, H,H,32'h4,32'h66, L,H,H,L,L,L, W8, 32'h55, 32'h4));
        cyc("lk p1 wacc",  mk(H,L,32'h10,0, H,H,32'h4,32'h66, L,L,L,L,L,L, W8, 32'h55, 0));
        p1_lock = 1'b0;
        cyc("lk release",  mk(H,L,32'h10,0, L,L,0,0, H,L,L,H,L,L, W8, 32'h55, 32'h10));
        cyc("lk p0 data",  mk(H,L,32'h10,0, L,L,0,0, L,L,L,L,H,L, AA, 32'h55, 0));
`else
        p1_lock = 1'b0;
        cyc("rr p0 first", mk(H,L,32'h10,0, H,H,32'h4,32'h66, H,L,L,H,L,L, W8, 32'h55, 32'h10));
        cyc("rr p0 data",  mk(H,L,32'h10,0, H,H,32'h4,32'h66, L,L,L,L,H,L, AA, 32'h55, 0));
        cyc("rr p1 write", mk(L,L,0,0,      H,H,32'h4,32'h66, L,H,H,L,L,L, AA, 32'h55, 32'h4));
        cyc("rr p1 wacc",  mk(L,L,0,0,      H,H,32'h4,32'h66, L,L,L,L,L,L, AA, 32'h55, 0));
`endif
        check("p1 write landed @0x4", {48'd0, mem[1]}, {48'd0, 32'h66});

        @(negedge clk);
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_data_mem_arbiter
`default_nettype wire
